// File: rtl/cycle_sequencer.sv
// cycle_sequencer: instruction-cycle controller. Walks fetch, decode and a
// per-opcode execute phase sequence. It stalls on memory phases, hands
// mul/div to an external unit with a bounded wait, and counts retired
// instructions. It also handles halt, stop-at-boundary and sticky faults.
module cycle_sequencer #(
   parameter int IR_W         = 32,
   parameter int OPC_W        = 5,
   parameter int CNT_W        = 32,
   parameter int EXEC_TIMEOUT = 64
) (
   input  logic             clk,
   input  logic             in_reset,
   input  logic [IR_W-1:0]  in_ir,
   input  logic             in_mem_ready,
   input  logic             in_exec_done,
   input  logic             in_stop,
   input  logic             in_resume,
   output logic             out_run,
   output logic [3:0]       out_state,
   output logic [OPC_W-1:0] out_opcode,
   output logic [2:0]       out_phase,
   output logic             out_mem_req,
   output logic             out_exec_start,
   output logic             out_retire,
   output logic [CNT_W-1:0] out_retired,
   output logic             out_fault,
   output logic [1:0]       out_fault_code
);

   typedef enum logic [3:0] {
      ST_RESET  = 4'd0,
      ST_FETCH0 = 4'd1,
      ST_FETCH1 = 4'd2,
      ST_FETCH2 = 4'd3,
      ST_DECODE = 4'd4,
      ST_EXEC   = 4'd5,
      ST_XWAIT  = 4'd6,
      ST_HALT   = 4'd7
   } state_t;

   // Index of the final execute phase (length minus one) for each opcode.
   function automatic logic [2:0] last_phase_f(input logic [OPC_W-1:0] opc);
      logic [2:0] lp;
      case (opc) inside
         5'd0:           lp = 3'd4;
         5'd1:           lp = 3'd2;
         5'd2:           lp = 3'd3;
         [5'd3:5'd13]:   lp = 3'd2;
         5'd14, 5'd15:   lp = 3'd3;
         5'd16, 5'd17:   lp = 3'd1;
         5'd18:          lp = 3'd3;
         5'd19:          lp = 3'd0;
         5'd20:          lp = 3'd1;
         [5'd21:5'd25]:  lp = 3'd0;
         default:        lp = 3'd0;
      endcase
      return lp;
   endfunction

   // Load phase 2 and store phase 3 wait on memory.
   function automatic logic is_mem_phase_f(input logic [OPC_W-1:0] opc, input logic [2:0] ph);
      return ((opc == 5'd0) && (ph == 3'd2)) || ((opc == 5'd2) && (ph == 3'd3));
   endfunction

   // mul and div run their phase 1 on the external execution unit.
   function automatic logic is_muldiv_f(input logic [OPC_W-1:0] opc);
      return (opc == 5'd14) || (opc == 5'd15);
   endfunction

   state_t             state_q, state_d;
   logic [OPC_W-1:0]   opcode_q, opcode_d;
   logic [2:0]         phase_q, phase_d;
   logic               run_q, run_d;
   logic               mem_req_q, mem_req_d;
   logic               exec_start_q, exec_start_d;
   logic               retire_q, retire_d;
   logic [CNT_W-1:0]   retired_q, retired_d;
   logic               fault_q, fault_d;
   logic [1:0]         fault_code_q, fault_code_d;
   logic               stop_pend_q, stop_pend_d;
   logic [7:0]         xcnt_q, xcnt_d;

   logic [OPC_W-1:0]   opc_in_s;
   logic               ir_unused_s;

   assign opc_in_s    = in_ir[IR_W-1 -: OPC_W];
   assign ir_unused_s = ^in_ir[IR_W-OPC_W-1:0];

   // Next-state, phase sequencing and registered-output next values.
   always_comb begin
      state_d      = state_q;
      opcode_d     = opcode_q;
      phase_d      = phase_q;
      retired_d    = retired_q;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      xcnt_d       = xcnt_q;
      exec_start_d = 1'b0;
      retire_d     = 1'b0;
      stop_pend_d  = stop_pend_q | in_stop;

      case (state_q)
         ST_RESET:  state_d = ST_FETCH0;
         ST_FETCH0: state_d = ST_FETCH1;
         ST_FETCH1: begin
            if (in_mem_ready) begin
               state_d = ST_FETCH2;
            end else begin
               state_d = ST_FETCH1;
            end
         end
         ST_FETCH2: state_d = ST_DECODE;
         ST_DECODE: begin
            opcode_d = opc_in_s;
            phase_d  = 3'd0;
            if (opc_in_s == 5'd26) begin
               state_d = ST_HALT;
            end else if (opc_in_s >= 5'd27) begin
               fault_d      = 1'b1;
               fault_code_d = 2'd1;
               state_d      = ST_HALT;
            end else begin
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if (is_mem_phase_f(opcode_q, phase_q) && !in_mem_ready) begin
               phase_d = phase_q;
            end else if (phase_q == last_phase_f(opcode_q)) begin
               retire_d  = 1'b1;
               retired_d = retired_q + {{(CNT_W-1){1'b0}}, 1'b1};
               // Instruction boundary: a stop arriving this very cycle still counts.
               if (stop_pend_q || in_stop) begin
                  state_d = ST_HALT;
               end else begin
                  state_d = ST_FETCH0;
               end
            end else if (is_muldiv_f(opcode_q) && (phase_q == 3'd0)) begin
               phase_d      = 3'd1;
               exec_start_d = 1'b1;
               xcnt_d       = 8'd0;
               state_d      = ST_XWAIT;
            end else begin
               phase_d = phase_q + 3'd1;
            end
         end
         ST_XWAIT: begin
            // Done is tested first so it wins over a simultaneous timeout.
            if (in_exec_done) begin
               phase_d = 3'd2;
               xcnt_d  = 8'd0;
               state_d = ST_EXEC;
            end else if (xcnt_q == 8'(EXEC_TIMEOUT - 1)) begin
               fault_d      = 1'b1;
               fault_code_d = 2'd2;
               xcnt_d       = 8'd0;
               state_d      = ST_HALT;
            end else begin
               xcnt_d = xcnt_q + 8'd1;
            end
         end
         ST_HALT: begin
            stop_pend_d = 1'b0;
            if (in_resume && !in_stop && !fault_q) begin
               state_d = ST_FETCH0;
            end else begin
               state_d = ST_HALT;
            end
         end
         default: state_d = ST_HALT;
      endcase

      run_d     = (state_d != ST_HALT);
      mem_req_d = (state_d == ST_FETCH0) || (state_d == ST_FETCH1) ||
                  ((state_d == ST_EXEC) && is_mem_phase_f(opcode_d, phase_d));
   end

   // State and output registers with immediate asynchronous reset.
   always_ff @(posedge clk or posedge in_reset) begin
      if (in_reset) begin
         state_q      <= ST_RESET;
         opcode_q     <= '0;
         phase_q      <= 3'd0;
         run_q        <= 1'b1;
         mem_req_q    <= 1'b0;
         exec_start_q <= 1'b0;
         retire_q     <= 1'b0;
         retired_q    <= '0;
         fault_q      <= 1'b0;
         fault_code_q <= 2'd0;
         stop_pend_q  <= 1'b0;
         xcnt_q       <= 8'd0;
      end else begin
         state_q      <= state_d;
         opcode_q     <= opcode_d;
         phase_q      <= phase_d;
         run_q        <= run_d;
         mem_req_q    <= mem_req_d;
         exec_start_q <= exec_start_d;
         retire_q     <= retire_d;
         retired_q    <= retired_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
         stop_pend_q  <= stop_pend_d;
         xcnt_q       <= xcnt_d;
      end
   end

   assign out_run        = run_q;
   assign out_state      = state_q;
   assign out_opcode     = opcode_q;
   assign out_phase      = phase_q;
   assign out_mem_req    = mem_req_q;
   assign out_exec_start = exec_start_q;
   assign out_retire     = retire_q;
   assign out_retired    = retired_q;
   assign out_fault      = fault_q;
   assign out_fault_code = fault_code_q;

endmodule

// File: tb/tb_cycle_sequencer.sv
// Bench for cycle_sequencer: a table of instructions with expected timing and
// pulse counts feeds a scoreboard queue, plus hand sequences for stop/resume,
// halt, faults, timeout and reset during XWAIT.
module tb_cycle_sequencer;
   localparam int IR_W = 32;
   localparam int OPC_W = 5;
   localparam int CNT_W = 32;

   logic             clk = 1'b0;
   logic             in_reset = 1'b0;
   logic [IR_W-1:0]  in_ir = '0;
   logic             in_mem_ready = 1'b1;
   logic             in_exec_done = 1'b0;
   logic             in_stop = 1'b0;
   logic             in_resume = 1'b0;
   logic             out_run;
   logic [3:0]       out_state;
   logic [OPC_W-1:0] out_opcode;
   logic [2:0]       out_phase;
   logic             out_mem_req;
   logic             out_exec_start;
   logic             out_retire;
   logic [CNT_W-1:0] out_retired;
   logic             out_fault;
   logic [1:0]       out_fault_code;

   cycle_sequencer #(.IR_W(IR_W), .OPC_W(OPC_W), .CNT_W(CNT_W), .EXEC_TIMEOUT(64)) dut (
      .clk(clk), .in_reset(in_reset), .in_ir(in_ir), .in_mem_ready(in_mem_ready),
      .in_exec_done(in_exec_done), .in_stop(in_stop), .in_resume(in_resume),
      .out_run(out_run), .out_state(out_state), .out_opcode(out_opcode),
      .out_phase(out_phase), .out_mem_req(out_mem_req), .out_exec_start(out_exec_start),
      .out_retire(out_retire), .out_retired(out_retired), .out_fault(out_fault),
      .out_fault_code(out_fault_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] opc;
      int         mw;        // memory-phase cycles with in_mem_ready low
      int         dw;        // XWAIT cycles before in_exec_done
      bit         stop_mid;  // pulse in_stop in EXEC phase 0
      int         cycles;    // cycles from FETCH0 to retire / HALT
      bit         retire;
      int         starts;
      int         memreq;
      logic [1:0] code;
   } vec_t;

   typedef struct {
      int         cycles;
      bit         retire;
      int         starts;
      int         memreq;
      logic [1:0] code;
      int         retired;
   } exp_t;

   exp_t sb_q[$];
   vec_t vecs[16];
   int   passed = 0;
   int   total = 0;
   int   exp_retired = 0;

   task automatic check(input string name, input longint act, input longint req);
      total++;
      if (act == req) begin
         passed++;
      end else begin
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] opc, input int mw, input int dw, input bit stp,
                               input int cyc, input bit ret, input int st, input int mr,
                               input logic [1:0] code);
      vec_t v;
      v.opc = opc; v.mw = mw; v.dw = dw; v.stop_mid = stp; v.cycles = cyc;
      v.retire = ret; v.starts = st; v.memreq = mr; v.code = code;
      return v;
   endfunction

   // Assert reset now, check reset values, release it just after a clock edge.
   task automatic do_reset();
      in_reset = 1'b1;
      in_mem_ready = 1'b1; in_exec_done = 1'b0; in_stop = 1'b0; in_resume = 1'b0;
      #1;
      check("rst_state", out_state, 0);
      check("rst_run", out_run, 1);
      check("rst_opcode", out_opcode, 0);
      check("rst_phase", out_phase, 0);
      check("rst_memreq", out_mem_req, 0);
      check("rst_start", out_exec_start, 0);
      check("rst_retire", out_retire, 0);
      check("rst_retired", out_retired, 0);
      check("rst_fault", out_fault, 0);
      check("rst_code", out_fault_code, 0);
      exp_retired = 0;
      @(posedge clk);
      @(posedge clk);
      #1 in_reset = 1'b0;
      @(negedge clk);
      check("rst_one_cycle", out_state, 0);
      @(negedge clk);
      check("rst_to_fetch0", out_state, 1);
      check("fetch0_memreq", out_mem_req, 1);
   endtask

   // Run one instruction starting at a FETCH0 negedge; stops at retire or HALT.
   task automatic run_instr(input vec_t v);
      exp_t e, got;
      int   cyc = 0, mw = 0, xw = 0, st = 0, mr = 0;
      bit   got_ret = 0, got_halt = 0, stopped = 0;
      e.cycles = v.cycles; e.retire = v.retire; e.starts = v.starts;
      e.memreq = v.memreq; e.code = v.code;
      if (v.retire) exp_retired++;
      e.retired = exp_retired;
      sb_q.push_back(e);
      in_ir = '0;
      in_ir[IR_W-1 -: OPC_W] = v.opc;
      for (int k = 0; k < 400; k++) begin
         if (cyc > 0 && out_retire) begin got_ret = 1; break; end
         if (cyc > 0 && out_state == 4'd7) begin got_halt = 1; break; end
         if (out_exec_start) st++;
         if (out_mem_req) mr++;
         if (out_state == 4'd5 && ((v.opc == 5'd0 && out_phase == 3'd2) ||
                                   (v.opc == 5'd2 && out_phase == 3'd3))) begin
            in_mem_ready = (mw >= v.mw);
            mw++;
         end else begin
            in_mem_ready = 1'b1;
         end
         if (out_state == 4'd6) begin
            in_exec_done = (xw >= v.dw);
            xw++;
         end else begin
            in_exec_done = 1'b0;
         end
         if (v.stop_mid && !stopped && out_state == 4'd5 && out_phase == 3'd0) begin
            in_stop = 1'b1;
            stopped = 1;
         end else begin
            in_stop = 1'b0;
         end
         cyc++;
         @(negedge clk);
      end
      in_mem_ready = 1'b1; in_exec_done = 1'b0; in_stop = 1'b0;
      check($sformatf("op%0d_ended", v.opc), got_ret | got_halt, 1);
      got = sb_q.pop_front();
      check($sformatf("op%0d_cycles", v.opc), cyc, got.cycles);
      check($sformatf("op%0d_retire", v.opc), got_ret, got.retire);
      check($sformatf("op%0d_starts", v.opc), st, got.starts);
      check($sformatf("op%0d_memreq", v.opc), mr, got.memreq);
      check($sformatf("op%0d_code", v.opc), out_fault_code, got.code);
      check($sformatf("op%0d_retired", v.opc), out_retired, got.retired);
   endtask

   initial begin
      vecs[0]  = mk(5'd3,  0, 0,  0, 7,  1, 0, 2, 2'd0);
      vecs[1]  = mk(5'd0,  0, 0,  0, 9,  1, 0, 3, 2'd0);
      vecs[2]  = mk(5'd0,  3, 0,  0, 12, 1, 0, 6, 2'd0);
      vecs[3]  = mk(5'd1,  0, 0,  0, 7,  1, 0, 2, 2'd0);
      vecs[4]  = mk(5'd2,  0, 0,  0, 8,  1, 0, 3, 2'd0);
      vecs[5]  = mk(5'd2,  2, 0,  0, 10, 1, 0, 5, 2'd0);
      vecs[6]  = mk(5'd14, 0, 0,  0, 8,  1, 1, 2, 2'd0);
      vecs[7]  = mk(5'd15, 0, 34, 0, 42, 1, 1, 2, 2'd0);
      vecs[8]  = mk(5'd16, 0, 0,  0, 6,  1, 0, 2, 2'd0);
      vecs[9]  = mk(5'd17, 0, 0,  0, 6,  1, 0, 2, 2'd0);
      vecs[10] = mk(5'd18, 0, 0,  0, 8,  1, 0, 2, 2'd0);
      vecs[11] = mk(5'd19, 0, 0,  0, 5,  1, 0, 2, 2'd0);
      vecs[12] = mk(5'd20, 0, 0,  0, 6,  1, 0, 2, 2'd0);
      vecs[13] = mk(5'd21, 0, 0,  0, 5,  1, 0, 2, 2'd0);
      vecs[14] = mk(5'd25, 0, 0,  0, 5,  1, 0, 2, 2'd0);
      vecs[15] = mk(5'd13, 0, 0,  0, 7,  1, 0, 2, 2'd0);

      #3;
      do_reset();
      for (int i = 0; i < 16; i++) begin
         run_instr(vecs[i]);
      end

      // Stop during mul phase 0: instruction completes, then HALT.
      run_instr(mk(5'd14, 0, 3, 1, 11, 1, 1, 2, 2'd0));
      check("stop_halt_state", out_state, 7);
      check("stop_halt_run", out_run, 0);
      in_resume = 1'b1; in_stop = 1'b1;
      @(negedge clk);
      check("resume_with_stop", out_state, 7);
      in_stop = 1'b0;
      @(negedge clk);
      check("resume_fetch0", out_state, 1);
      check("resume_run", out_run, 1);
      in_resume = 1'b0;

      // Halt opcode: clean HALT, resumable.
      run_instr(mk(5'd26, 0, 0, 0, 4, 0, 0, 2, 2'd0));
      check("halt26_fault", out_fault, 0);
      in_resume = 1'b1;
      @(negedge clk);
      check("halt26_resume", out_state, 1);
      in_resume = 1'b0;

      // Illegal opcode: fault code 1, resume ignored.
      run_instr(mk(5'd29, 0, 0, 0, 4, 0, 0, 2, 2'd1));
      check("ill_fault", out_fault, 1);
      check("ill_run", out_run, 0);
      in_resume = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("ill_resume_ignored", out_state, 7);
      in_resume = 1'b0;
      do_reset();

      // Execution timeout: div without done.
      run_instr(mk(5'd15, 0, 1000, 0, 69, 0, 1, 2, 2'd2));
      check("tmo_fault", out_fault, 1);
      in_resume = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("tmo_resume_ignored", out_state, 7);
      in_resume = 1'b0;
      do_reset();

      // Reset in the middle of XWAIT.
      run_instr(vecs[0]);
      in_ir = '0;
      in_ir[IR_W-1 -: OPC_W] = 5'd15;
      for (int k = 0; k < 40; k++) begin
         if (out_state == 4'd6) break;
         @(negedge clk);
      end
      check("reach_xwait", out_state, 6);
      repeat (5) @(negedge clk);
      check("still_xwait", out_state, 6);
      #2;
      do_reset();
      run_instr(vecs[0]);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/cycle_sequencer.md
CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 Parameters: IR_W, 32, instruction register width; OPC_W, 5, opcode field width taken from in_ir[IR_W-1:IR_W-OPC_W]; CNT_W, 32, retired-instruction counter width; EXEC_TIMEOUT, 64, maximum in_exec_done wait cycles (2..255).
REQ-002 Ports shall be:
- clk in 1: clock.
- in_reset in 1: reset, asynchronous, active-high.
- in_ir in IR_W: current instruction register contents.
- in_mem_ready in 1: memory completed the requested access this cycle.
- in_exec_done in 1: multi-cycle execution unit finished.
- in_stop in 1: request halt at the next instruction boundary.
- in_resume in 1: leave a non-fault halt.
- out_run out 1: machine running.
- out_state out 4: current state encoding.
- out_opcode out OPC_W: latched opcode.
- out_phase out 3: execute phase index.
- out_mem_req out 1: memory access requested.
- out_exec_start out 1: one-cycle start pulse to the execution unit.
- out_retire out 1: one-cycle instruction-complete pulse.
- out_retired out CNT_W: retired-instruction count.
- out_fault out 1: sticky fault flag.
- out_fault_code out 2: 0 none, 1 illegal opcode, 2 execution timeout.

Function
REQ-003 State encodings shall be RESET=0, FETCH0=1, FETCH1=2, FETCH2=3, DECODE=4, EXEC=5, XWAIT=6, HALT=7; all other values are unreachable and shall go to HALT.
REQ-004 RESET shall last one cycle after in_reset deasserts, then go to FETCH0.
REQ-005 FETCH0 shall assert out_mem_req for one cycle and then go to FETCH1.
REQ-006 FETCH1 shall hold out_mem_req=1 until in_mem_ready=1, then go to FETCH2; this gives zero wait states minimum.
REQ-007 FETCH2 (external IR load cycle) shall go to DECODE.
REQ-008 DECODE shall latch out_opcode from in_ir, clear out_phase to 0, and go to EXEC.
  - Exception: opcode 26 (halt) shall go to HALT.
  - Exception: opcodes 27..31 shall set out_fault=1 and code 1, then go to HALT.
REQ-009 Execute lengths in phases by opcode shall be:
  - load(0)=5; loadi(1)=3; store(2)=4.
  - ALU/immediate(3..13)=3.
  - mul(14)=4; div(15)=4.
  - neg/not(16,17)=2; branch(18)=4; jr(19)=1; jal(20)=2.
  - in/out/mfhi/mflo/nop(21..25)=1.
REQ-010 EXEC shall increment out_phase once per cycle, except on a memory phase or an execution phase.
REQ-011 Memory phases are load phase 2 and store phase 3; in these out_mem_req=1 and out_phase holds until in_mem_ready=1.
REQ-012 Execution phase is phase 1 of mul/div. On entry to this phase:
  - out_exec_start pulses for one cycle and the state goes to XWAIT.
  - XWAIT counts cycles; when in_exec_done=1 the state returns to EXEC with out_phase=2.
REQ-013 If in_exec_done has not arrived when the XWAIT count reaches EXEC_TIMEOUT, the block shall set out_fault=1, code 2, and go to HALT. If done and timeout occur in the same cycle, done wins.
REQ-014 On the last phase of an instruction, out_retire shall pulse and out_retired shall increment, wrapping modulo 2^CNT_W.
  - The next state is FETCH0, or HALT if a stop is pending.
REQ-015 A pulse on in_stop in any state shall set a sticky stop-pending bit; it is honoured only at an instruction boundary, never mid-instruction.
REQ-016 HALT shall drive out_run=0 and clear stop-pending.
  - in_resume=1 with out_fault=0 shall go to FETCH0.
  - in_resume with in_stop in the same cycle shall keep HALT.
  - When out_fault=1, in_resume shall be ignored.
REQ-017 out_run shall be 1 in every state except HALT.
REQ-018 out_mem_req shall be 0 outside FETCH0, FETCH1 and memory phases; out_exec_start shall be 0 except on the XWAIT entry cycle.

Reset
REQ-019 in_reset shall take effect immediately, including mid-instruction or mid-XWAIT.
REQ-020 Reset values shall be:
  - state RESET; out_run=1; out_opcode=0; out_phase=0.
  - out_mem_req=0; out_exec_start=0; out_retire=0; out_retired=0.
  - out_fault=0; out_fault_code=0; stop-pending=0; XWAIT count=0.

Verification
REQ-021 add (opcode 3), in_mem_ready tied 1 -> states 1,2,3,4,5x3; out_retire pulses on the 8th cycle after RESET; out_retired=1.
REQ-022 load, in_mem_ready low 3 cycles in phase 2 -> out_phase holds at 2 for 4 cycles with out_mem_req=1; load retires 3 cycles later than with zero wait states.
REQ-023 div, in_exec_done after 34 XWAIT cycles -> exactly one out_exec_start pulse; returns to EXEC with phase 2; retires normally. Same test with done never asserted -> HALT after 64 cycles, out_fault_code=2, and in_resume is ignored.
REQ-024 in_stop pulsed during mul phase 0 -> mul completes and retires, then HALT (out_run=0); in_resume -> FETCH0.
REQ-025 opcode 29 -> HALT, out_fault=1, code 1, out_retired unchanged.
REQ-026 in_reset asserted during XWAIT -> all outputs at reset values immediately; fetch restarts after one RESET cycle.
